// File: rtl/riscv_mdu_if.sv
// Execute-stage handshake between the pipeline and the RV64M multiply/divide unit.
interface riscv_mdu_if;
    logic        i_riscv_mdu_start;
    logic [2:0]  i_riscv_mdu_funct3;
    logic        i_riscv_mdu_word;
    logic [63:0] i_riscv_mdu_rs1data;
    logic [63:0] i_riscv_mdu_rs2data;
    logic        i_riscv_mdu_flush;
    logic [63:0] o_riscv_mdu_result;
    logic        o_riscv_mdu_valid;
    logic        o_riscv_mdu_stall;

    modport master (
        output i_riscv_mdu_start, i_riscv_mdu_funct3, i_riscv_mdu_word,
               i_riscv_mdu_rs1data, i_riscv_mdu_rs2data, i_riscv_mdu_flush,
        input  o_riscv_mdu_result, o_riscv_mdu_valid, o_riscv_mdu_stall
    );

    modport slave (
        input  i_riscv_mdu_start, i_riscv_mdu_funct3, i_riscv_mdu_word,
               i_riscv_mdu_rs1data, i_riscv_mdu_rs2data, i_riscv_mdu_flush,
        output o_riscv_mdu_result, o_riscv_mdu_valid, o_riscv_mdu_stall
    );
endinterface

// File: rtl/riscv_mdu.sv
// Iterative RV64M unit: radix-2 shift-add multiplier and restoring divider sharing one
// 128-bit hi/lo datapath, one bit per cycle, stalling the front end until done.
module riscv_mdu (
    input  logic       i_riscv_mdu_clk,
    input  logic       i_riscv_mdu_rst,
    riscv_mdu_if.slave mdu
);
    localparam logic [63:0] Min64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] Min32 = 64'hFFFF_FFFF_8000_0000;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] opb_q, opb_d;
    logic [63:0] hi_q, hi_d;
    logic [63:0] lo_q, lo_d;
    logic [63:0] result_q, result_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        word_q, word_d;
    logic        neg_q, neg_d;
    logic        neg_rem_q, neg_rem_d;

    logic        start, flush, word;
    logic [2:0]  funct3;
    logic [63:0] rs1, rs2;

    assign start  = mdu.i_riscv_mdu_start;
    assign flush  = mdu.i_riscv_mdu_flush;
    assign word   = mdu.i_riscv_mdu_word;
    assign funct3 = mdu.i_riscv_mdu_funct3;
    assign rs1    = mdu.i_riscv_mdu_rs1data;
    assign rs2    = mdu.i_riscv_mdu_rs2data;

    logic        is_div, sign_a, sign_b, a_neg, b_neg, div_zero, div_ovf;
    logic [63:0] a_sext32, a_ext, b_ext, a_mag, b_mag;

    // Operand conditioning at accept; word multiplies only need the low 32 product bits,
    // so they run unsigned like MUL.
    always_comb begin
        is_div   = funct3[2];
        sign_a   = is_div ? ~funct3[0]
                          : (~word & ((funct3[1:0] == 2'b01) | (funct3[1:0] == 2'b10)));
        sign_b   = is_div ? ~funct3[0] : (~word & (funct3[1:0] == 2'b01));
        a_sext32 = {{32{rs1[31]}}, rs1[31:0]};
        a_ext    = word ? (sign_a ? a_sext32 : {32'b0, rs1[31:0]}) : rs1;
        b_ext    = word ? {{32{sign_b & rs2[31]}}, rs2[31:0]} : rs2;
        a_neg    = sign_a & a_ext[63];
        b_neg    = sign_b & b_ext[63];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        div_ovf  = sign_a & (a_ext == (word ? Min32 : Min64)) & (b_ext == '1);
    end

    logic [64:0] mul_sum, rem_sh, diff;
    logic [63:0] hi_n, lo_n, prod_hi, quo, rem, div_sel, fin;
    logic        last;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 65'd0);
        rem_sh  = {hi_q, lo_q[63]};
        diff    = rem_sh - {1'b0, opb_q};
        if (state_q == StDiv) begin
            hi_n = diff[64] ? rem_sh[63:0] : diff[63:0];
            lo_n = {lo_q[62:0], ~diff[64]};
        end else begin
            hi_n = mul_sum[64:1];
            lo_n = {mul_sum[0], lo_q[63:1]};
        end
        // Upper half of the negated 128-bit product: carry into it only when the low half is 0.
        prod_hi = neg_q ? (~hi_n + {63'b0, (lo_n == '0)}) : hi_n;
        quo     = neg_q ? -lo_n : lo_n;
        rem     = neg_rem_q ? -hi_n : hi_n;
        div_sel = funct3_q[1] ? rem : quo;
        if (state_q == StDiv) begin
            fin = word_q ? {{32{div_sel[31]}}, div_sel[31:0]} : div_sel;
        end else if (word_q) begin
            // After 32 right shifts the product sits at bit 32 of the accumulator.
            fin = {{32{lo_n[63]}}, lo_n[63:32]};
        end else if (funct3_q[1:0] == 2'b00) begin
            fin = lo_n;
        end else begin
            fin = prod_hi;
        end
        last = (cnt_q == 7'd1);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        funct3_d  = funct3_q;
        word_d    = word_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    funct3_d  = funct3;
                    word_d    = word;
                    cnt_d     = word ? 7'd32 : 7'd64;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (!is_div) begin
                        state_d = StMul;
                        opb_d   = a_mag;
                        hi_d    = '0;
                        lo_d    = b_mag;
                    end else if (div_zero) begin
                        state_d  = StDone;
                        result_d = funct3[1] ? (word ? a_sext32 : rs1) : '1;
                    end else if (div_ovf) begin
                        state_d  = StDone;
                        result_d = funct3[1] ? '0 : a_ext;
                    end else begin
                        state_d = StDiv;
                        opb_d   = b_mag;
                        hi_d    = '0;
                        lo_d    = word ? {a_mag[31:0], 32'b0} : a_mag;
                    end
                end
            end
            StMul, StDiv: begin
                cnt_d = cnt_q - 7'd1;
                hi_d  = hi_n;
                lo_d  = lo_n;
                if (last) begin
                    state_d  = StDone;
                    result_d = fin;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge i_riscv_mdu_clk or negedge i_riscv_mdu_rst) begin
        if (!i_riscv_mdu_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            funct3_q  <= '0;
            word_q    <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            funct3_q  <= funct3_d;
            word_q    <= word_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign mdu.o_riscv_mdu_result = result_q;
    assign mdu.o_riscv_mdu_valid  = (state_q == StDone) & ~flush;
    assign mdu.o_riscv_mdu_stall  = i_riscv_mdu_rst & ~flush &
                                    (((state_q == StIdle) & start) |
                                     (state_q == StMul) | (state_q == StDiv));
endmodule
